seq_multiplier: RTL and testbench

Parametrised iterative shift-add multiplier for the CPU datapath ALU. It accepts two WIDTH-bit operands on a start/done handshake and returns the full 2*WIDTH-bit product after a fixed WIDTH+1 cycles. Signed (two's-complement) and unsigned modes are supported, along with an overflow flag for WIDTH-bit truncation. It supersedes the single-cycle 16-bit truncating array multiplier, trading latency for area.

---
 rtl/seq_multiplier.sv | 111 +++++++++++
 tb/tb_seq_multiplier.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: WIDTH+1 cycles per operation, full
// 2*WIDTH-bit product, signed or unsigned operands, truncation overflow flag.
// Signed operands are multiplied as magnitudes and the sign is applied once
// at the end, so the datapath only ever does unsigned additions.
module seq_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   rs,
    input  logic [WIDTH-1:0]   rd,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   q,
    output logic               overflow
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH);

    logic [0:0]         state;
    logic [CW-1:0]      count;
    logic               mode;
    logic               neg;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   acc_hi;
    // Low half of the accumulator shares this register with the multiplier.
    logic [WIDTH-1:0]   mplier;

    logic [WIDTH-1:0]   mag_rs;
    logic [WIDTH-1:0]   mag_rd;
    logic [WIDTH:0]     sum_full;
    logic [2*WIDTH-1:0] magnitude;
    logic [2*WIDTH-1:0] result;
    logic [WIDTH:0]     upper_s;
    logic               ovf_next;

    // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1), which
    // still fits in WIDTH unsigned bits.
    always_comb begin
        mag_rs = (signed_mode && rs[WIDTH-1]) ? -rs : rs;
        mag_rd = (signed_mode && rd[WIDTH-1]) ? -rd : rd;
    end

    // One shift-add step plus the sign-corrected result and its overflow test.
    always_comb begin
        sum_full  = {1'b0, acc_hi} + {1'b0, (mplier[0] ? mcand : '0)};
        magnitude = {acc_hi, mplier};
        result    = neg ? -magnitude : magnitude;
        upper_s   = result[2*WIDTH-1:WIDTH-1];
        if (mode)
            ovf_next = !((&upper_s) || !(|upper_s));
        else
            ovf_next = |result[2*WIDTH-1:WIDTH];
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            mode     <= 1'b0;
            neg      <= 1'b0;
            mcand    <= '0;
            acc_hi   <= '0;
            mplier   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            product  <= '0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mode   <= signed_mode;
                        neg    <= signed_mode & (rs[WIDTH-1] ^ rd[WIDTH-1]);
                        mcand  <= mag_rs;
                        mplier <= mag_rd;
                        acc_hi <= '0;
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                default: begin
                    if (count == LAST) begin
                        product  <= result;
                        overflow <= ovf_next;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        acc_hi <= sum_full[WIDTH:1];
                        mplier <= {sum_full[0], mplier[WIDTH-1:1]};
                        count  <= count + 1'b1;
                    end
                end
            endcase
        end
    end

    assign q = product[WIDTH-1:0];

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: directed WIDTH=16 cases (handshake, ignored
// re-starts, back-to-back starts, mid-operation reset) and randomized
// WIDTH=8 operations against an integer-arithmetic reference model.
module tb_seq_multiplier;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        start16 = 1'b0, sm16 = 1'b0;
    logic [15:0] rs16 = '0, rd16 = '0;
    logic        busy16, done16, ovf16;
    logic [31:0] prod16;
    logic [15:0] q16;

    logic        start8 = 1'b0, sm8 = 1'b0;
    logic [7:0]  rs8 = '0, rd8 = '0;
    logic        busy8, done8, ovf8;
    logic [15:0] prod8;
    logic [7:0]  q8;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16),
        .rs(rs16), .rd(rd16), .busy(busy16), .done(done16),
        .product(prod16), .q(q16), .overflow(ovf16)
    );

    seq_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
        .rs(rs8), .rd(rd8), .busy(busy8), .done(done8),
        .product(prod8), .q(q8), .overflow(ovf8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: true integer product, truncated to 2w bits, overflow judged
    // against the representable WIDTH-bit range of the chosen mode.
    function automatic void ref_mul(input int w, input bit sm, input logic [15:0] a,
                                    input logic [15:0] b, output logic [31:0] p, output bit ov);
        longint av, bv, pv, mask;
        av = longint'(a);
        bv = longint'(b);
        if (sm && a[w-1]) av = av - (longint'(1) << w);
        if (sm && b[w-1]) bv = bv - (longint'(1) << w);
        pv   = av * bv;
        mask = (longint'(1) << (2 * w)) - 1;
        p    = 32'(pv & mask);
        if (sm) ov = (pv < -(longint'(1) << (w - 1))) || (pv >= (longint'(1) << (w - 1)));
        else    ov = pv >= (longint'(1) << w);
    endfunction

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic run16(input bit sm, input logic [15:0] a, input logic [15:0] b,
                         input bit repulse, output logic [31:0] p, output logic ov,
                         output logic [15:0] qv, output int lat);
        int gaps = 0;
        start16 = 1'b1; sm16 = sm; rs16 = a; rd16 = b;
        @(posedge clk);
        @(negedge clk);
        start16 = 1'b0; rs16 = 16'($urandom); rd16 = 16'($urandom); sm16 = ~sm;
        check("busy_after_start", busy16, 1);
        lat = -1; p = '0; ov = 1'b0; qv = '0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done16) begin
                lat = i; p = prod16; ov = ovf16; qv = q16;
                check("busy_in_done", busy16, 0);
                break;
            end
            if (!busy16) gaps++;
            if (repulse && (i == 3 || i == 10)) begin
                start16 = 1'b1; rs16 = 16'($urandom); rd16 = 16'($urandom);
                sm16 = 1'($urandom);
            end else begin
                start16 = 1'b0;
            end
        end
        start16 = 1'b0;
        check("busy_held", 64'(gaps), 0);
        if (lat < 0) check("done_timeout16", 0, 1);
    endtask

    task automatic directed(input string tag, input bit sm, input logic [15:0] a,
                            input logic [15:0] b, input logic [31:0] exp_p,
                            input bit exp_ov, input bit repulse);
        logic [31:0] p; logic ov; logic [15:0] qv; int lat;
        run16(sm, a, b, repulse, p, ov, qv, lat);
        check({tag, "_product"}, p, exp_p);
        check({tag, "_q"}, qv, exp_p[15:0]);
        check({tag, "_ovf"}, ov, exp_ov);
        check({tag, "_latency"}, 64'(lat), 17);
    endtask

    task automatic run8(input bit sm, input logic [7:0] a, input logic [7:0] b);
        logic [31:0] ep; bit eov; int lat = -1;
        ref_mul(8, sm, {8'h00, a}, {8'h00, b}, ep, eov);
        start8 = 1'b1; sm8 = sm; rs8 = a; rd8 = b;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0; rs8 = 8'($urandom); rd8 = 8'($urandom);
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (done8) begin
                lat = i;
                break;
            end
        end
        check("w8_product", prod8, ep[15:0]);
        check("w8_ovf", ovf8, eov);
        check("w8_latency", 64'(lat), 9);
    endtask

    initial begin
        logic [31:0] p; logic ov; logic [15:0] qv; int lat;

        repeat (2) @(negedge clk);
        check("rst_busy", busy16, 0);
        check("rst_done", done16, 0);
        check("rst_product", prod16, 0);
        check("rst_q", q16, 0);
        check("rst_ovf", ovf16, 0);
        check("rst_product8", prod8, 0);
        rst = 1'b0;

        directed("u_3x5",     1'b0, 16'd3,    16'd5,    32'h0000000F, 1'b0, 1'b0);
        directed("u_max",     1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b1, 1'b0);
        directed("s_m3x5",    1'b1, 16'hFFFD, 16'h0005, 32'hFFFFFFF1, 1'b0, 1'b1);
        directed("s_m1xm1",   1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001, 1'b0, 1'b0);
        directed("s_minx1",   1'b1, 16'h8000, 16'h0001, 32'hFFFF8000, 1'b0, 1'b1);
        directed("s_zero_neg",1'b1, 16'h0000, 16'hFFF0, 32'h00000000, 1'b0, 1'b0);
        directed("s_minxmin", 1'b1, 16'h8000, 16'h8000, 32'h40000000, 1'b1, 1'b0);

        // Abort an operation with reset at cycle 8.
        @(negedge clk);
        start16 = 1'b1; sm16 = 1'b0; rs16 = 16'h1234; rd16 = 16'h0101;
        @(posedge clk);
        @(negedge clk);
        start16 = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", busy16, 0);
        check("abort_done", done16, 0);
        check("abort_product", prod16, 0);
        check("abort_q", q16, 0);
        check("abort_ovf", ovf16, 0);
        begin
            int pulses = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (done16) pulses++;
                if (i == 2) rst = 1'b0;
            end
            check("abort_no_done", 64'(pulses), 0);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run16(1'b0, 16'd7, 16'd9, 1'b0, p, ov, qv, lat);
        check("post_rst_product", p, 32'd63);
        check("post_rst_latency", 64'(lat), 17);

        @(negedge clk);
        for (int n = 0; n < 1000; n++)
            run8(1'($urandom), 8'($urandom), 8'($urandom));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
